mux21_arb: RTL
==============

Name: mux21_arb

Overview:
- Round-robin arbiter that shares one 2:1 mux output channel between two valid/ready requesters, A and B.
- Sequences the mux select `s` and registers the winning beat into a one-entry output stage.
- Caps consecutive grants to one requester at MAX_BURST while the other requester is waiting.
- Sits between two producer blocks and a single downstream consumer.

Parameters:
- W, 8: data width of a_data, b_data and o_data.
- MAX_BURST, 4: maximum consecutive beats granted to one requester while the other is valid; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- a_valid  input  1  requester A has a beat.
- a_data  input  W  requester A payload.
- a_ready  output  1  A's beat is accepted this cycle.
- b_valid  input  1  requester B has a beat.
- b_data  input  W  requester B payload.
- b_ready  output  1  B's beat is accepted this cycle.
- o_valid  output  1  output register holds a beat.
- o_data  output  W  output payload.
- o_ready  input  1  consumer accepts o_data.
- s  output  1  mux select of the beat in the output register (0=A, 1=B).
- busy  output  1  FSM is not in IDLE.

Behaviour:
- Reset (asynchronous, active-low):
  - o_valid=0, o_data=0, s=0, busy=0.
  - state=IDLE, burst_cnt=0, last=1, so A wins the first tie.
  - Asserting rst_n low mid-transfer drops o_valid immediately; the held beat is discarded.
- load = !o_valid | o_ready.
- Grant g (combinational) is computed from state and valids (see FSM). a_ready = load & (g==0); b_ready = load & (g==1).
  - a_ready/b_ready may be high while the matching valid is low; no transfer occurs in that case.
- Transfer on X = X_valid & X_ready. On a transfer:
  - o_data <= X_data, o_valid <= 1, s <= g, last <= g.
  - Latency is 1 clock from accept to o_valid.
- If o_ready & o_valid and there is no transfer: o_valid <= 0, and o_data and s hold.
- When the output register is full and o_ready=0, both readies are 0. o_data and s hold stable.
- FSM states: IDLE, SERVE_A, SERVE_B.
  - IDLE, no valid: g=last, stay.
  - IDLE, one valid: g=that requester.
  - IDLE, both valid: g = !last.
  - IDLE on a transfer: go to SERVE_g with burst_cnt=1.
  - SERVE_A, A valid and (burst_cnt<MAX_BURST or !b_valid): g=A. On a transfer burst_cnt increments, saturating at MAX_BURST; when saturated with !b_valid it reloads to 1.
  - SERVE_A, A valid, burst_cnt==MAX_BURST and b_valid: g=B. On a transfer go to SERVE_B with burst_cnt=1.
  - SERVE_A, !A valid and b_valid: g=B. On a transfer go to SERVE_B with burst_cnt=1.
  - SERVE_A, no valid: go to IDLE next cycle; burst_cnt is retained until the next grant.
  - SERVE_B mirrors SERVE_A.
- State only advances when load=1, except the no-valid -> IDLE transition, which is unconditional.
- burst_cnt is 4 bits wide.
- busy = (state != IDLE).
- Throughput: one beat per clock when o_ready stays high.

Optional Feature:
- Macro: MUX21_ARB_STATS_EN.
- When defined:
  - Adds output ports a_cnt[15:0] and b_cnt[15:0].
  - Each counts accepted beats per requester, saturating at 16'hFFFF.
  - Both clear on rst_n low.
  - Adds input stat_clr, which zeroes both counters synchronously; stat_clr has priority over an increment in the same cycle.
- When undefined: these ports and registers do not exist, and the remaining behaviour is identical.

Test Plan:
- Reset, then a_valid=b_valid=1 with o_ready=1 -> first beat is from A (s=0 on cycle 1), with o_data=a_data one clock after accept.
- Both requesters continuously valid, MAX_BURST=4, o_ready=1 -> s sequence 0,0,0,0,1,1,1,1,0... and every beat is transferred exactly once.
- Only A valid for 10 beats, o_ready=1 -> 10 consecutive A beats with no bubble, s=0 throughout; b_ready's value is irrelevant because no B transfer occurs.
- Output full with o_ready=0 for 3 cycles -> a_ready=b_ready=0, and o_data/s/o_valid are stable. On o_ready=1, the next beat loads in the same cycle.
- rst_n pulsed low while o_valid=1 and in SERVE_B -> o_valid=0 asynchronously. After release, state=IDLE and the first tie goes to A.
- With MUX21_ARB_STATS_EN: 5 A beats and 3 B beats -> a_cnt=5, b_cnt=3. Asserting stat_clr in the same cycle as a transfer -> both counters read 0.

Source files
------------

// File: rtl/mux21_arb_if.sv
// Handshake bundle between the mux21_arb arbiter and its environment.
// The arbiter connects through the master modport (it drives the readies and the output stage).
// The producer/consumer side connects through the slave modport.
interface mux21_arb_if #(
    parameter int W = 8
);
    logic         a_valid;
    logic [W-1:0] a_data;
    logic         a_ready;
    logic         b_valid;
    logic [W-1:0] b_data;
    logic         b_ready;
    logic         o_valid;
    logic [W-1:0] o_data;
    logic         o_ready;
    logic         s;
    logic         busy;

    modport master (
        input  a_valid, a_data, b_valid, b_data, o_ready,
        output a_ready, b_ready, o_valid, o_data, s, busy
    );

    modport slave (
        output a_valid, a_data, b_valid, b_data, o_ready,
        input  a_ready, b_ready, o_valid, o_data, s, busy
    );
endinterface

// File: rtl/mux21_arb.sv
// Round-robin arbiter that shares a 2:1 mux output between requesters A and B.
// Each requester gets at most MAX_BURST consecutive beats while the other one waits.
// The winning beat is registered into a one-entry output stage.
// Optional macro MUX21_ARB_STATS_EN adds per-requester accepted-beat counters.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no requester being served; ties go to the requester not granted last
// SERVE_A | A holds the grant; burst_cnt counts its consecutive beats
// SERVE_B | B holds the grant; burst_cnt counts its consecutive beats
module mux21_arb #(
    parameter int W         = 8,
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    mux21_arb_if.master        bus
`ifdef MUX21_ARB_STATS_EN
    ,
    input  logic               stat_clr,
    output logic [15:0]        a_cnt,
    output logic [15:0]        b_cnt
`endif
);
    typedef enum logic [1:0] {IDLE, SERVE_A, SERVE_B} state_t;

    localparam logic [3:0] MAX_B = 4'(MAX_BURST);

    state_t       state, state_nxt;
    logic [3:0]   burst_cnt, burst_nxt;
    logic         last;
    logic         g;
    logic         load;
    logic         xfer;
    logic         o_valid_q;
    logic [W-1:0] o_data_q;
    logic         s_q;

    assign load = !o_valid_q | bus.o_ready;

    // State register: FSM state, burst length and last winner
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            burst_cnt <= 4'd0;
            last      <= 1'b1;
        end else begin
            state     <= state_nxt;
            burst_cnt <= burst_nxt;
            if (xfer) last <= g;
        end
    end

    // Next-state: grant selection, transfer detection and burst accounting
    always_comb begin
        g         = last;
        state_nxt = state;
        burst_nxt = burst_cnt;
        case (state)
            IDLE: begin
                if (bus.a_valid && bus.b_valid) g = !last;
                else if (bus.a_valid)           g = 1'b0;
                else if (bus.b_valid)           g = 1'b1;
            end
            SERVE_A: begin
                if (bus.a_valid && (burst_cnt < MAX_B || !bus.b_valid)) g = 1'b0;
                else if (bus.b_valid)                                    g = 1'b1;
            end
            SERVE_B: begin
                if (bus.b_valid && (burst_cnt < MAX_B || !bus.a_valid)) g = 1'b1;
                else if (bus.a_valid)                                    g = 1'b0;
            end
            default: ;
        endcase

        xfer = load & (g ? bus.b_valid : bus.a_valid);

        if (xfer) begin
            state_nxt = g ? SERVE_B : SERVE_A;
            // Continuing the same requester extends the burst; a saturated burst
            // only continues when the other side is idle, so it restarts at 1.
            if ((state == SERVE_A && !g) || (state == SERVE_B && g))
                burst_nxt = (burst_cnt >= MAX_B) ? 4'd1 : burst_cnt + 4'd1;
            else
                burst_nxt = 4'd1;
        end else if (!bus.a_valid && !bus.b_valid) begin
            // Falling back to IDLE does not wait for the output stage to drain
            state_nxt = IDLE;
        end
    end

    // Outputs: readies follow the grant whenever the output stage can load
    always_comb begin
        bus.a_ready = load & !g;
        bus.b_ready = load & g;
        bus.busy    = (state != IDLE);
        bus.o_valid = o_valid_q;
        bus.o_data  = o_data_q;
        bus.s       = s_q;
    end

    // Output stage: capture the granted beat, drop valid once consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
            s_q       <= 1'b0;
        end else if (xfer) begin
            o_valid_q <= 1'b1;
            o_data_q  <= g ? bus.b_data : bus.a_data;
            s_q       <= g;
        end else if (bus.o_ready && o_valid_q) begin
            o_valid_q <= 1'b0;
        end
    end

`ifdef MUX21_ARB_STATS_EN
    // Accepted-beat counters, saturating; a clear wins over an increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_cnt <= 16'd0;
            b_cnt <= 16'd0;
        end else if (stat_clr) begin
            a_cnt <= 16'd0;
            b_cnt <= 16'd0;
        end else if (xfer) begin
            if (!g && a_cnt != 16'hFFFF) a_cnt <= a_cnt + 16'd1;
            if (g && b_cnt != 16'hFFFF)  b_cnt <= b_cnt + 16'd1;
        end
    end
`endif
endmodule
